ntt_bram_ctrl: RTL and testbench

Parametrised BRAM-to-NTT transfer controller.
- On `start`, reads N coefficients from a BRAM input region into a local x buffer, then releases an external NTT core from reset and waits for its `core_done`.
- Captures the core's y vector, writes N results to a BRAM output region, then pulses `done`.
- Generalises the fixed 64-point/64-bit loader: width, point count, region bases, BRAM read latency and address scaling are parameters, and there is an explicit start/busy/done handshake.

---
 rtl/ntt_bram_ctrl_pkg.sv | 24 ++
 rtl/ntt_bram_ctrl_if.sv | 34 +++
 rtl/ntt_bram_ctrl_rd_tracker.sv | 39 +++
 rtl/ntt_bram_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ntt_bram_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_bram_ctrl_pkg.sv
// Shared types and helpers for the BRAM-to-NTT transfer controller.
package ntt_pkg;

   // Deepest BRAM read pipeline the read tracker supports.
   localparam int MAX_RD_LAT = 3;

   // Default coefficient type; blocks with a different DATA_W declare
   // their own logic [DATA_W-1:0] alias of the same shape.
   localparam int COEF_W = 64;
   typedef logic [COEF_W-1:0] coef_t;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, STORE, FIN} state_e;

   // Reverse the low 'bits' bits of idx; upper bits of the result are zero.
   function automatic int unsigned bitrev(input int unsigned idx, input int unsigned bits);
      int unsigned r;
      r = 0;
      for (int b = 0; b < 32; b++) begin
         if (b < bits) r[bits-1-b] = idx[b];
      end
      return r;
   endfunction

endpackage

// File: rtl/ntt_bram_ctrl_if.sv
// Bus bundle between the transfer controller, the BRAM port and the NTT core.
// master = controller side, slave = BRAM/core/host side.
interface ntt_bram_ctrl_if #(
   parameter int N      = 64,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 12
);
   logic                start;
   logic                busy;
   logic                done;
   logic [ADDR_W-1:0]   BRAM_addr;
   logic                BRAM_clk;
   logic [DATA_W-1:0]   BRAM_din;
   logic [DATA_W-1:0]   BRAM_dout;
   logic                BRAM_en;
   logic                BRAM_rst;
   logic                BRAM_we;
   logic                core_rst;
   logic [N*DATA_W-1:0] core_x;
   logic [N*DATA_W-1:0] core_y;
   logic                core_done;

   modport master (
      input  start, BRAM_dout, core_y, core_done,
      output busy, done, BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst,
             BRAM_we, core_rst, core_x
   );

   modport slave (
      output start, BRAM_dout, core_y, core_done,
      input  busy, done, BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst,
             BRAM_we, core_rst, core_x
   );
endinterface

// File: rtl/ntt_bram_ctrl_rd_tracker.sv
// bram_rd_tracker: tags each issued BRAM read with its coefficient index and
// presents the tag again exactly when the read data appears on BRAM_dout.
module bram_rd_tracker
   import ntt_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int IDX_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_issue,
   input  logic [IDX_W-1:0] i_index,
   output logic             o_cap_valid,
   output logic [IDX_W-1:0] o_cap_index
);
   // Depth is held to the supported 1..MAX_RD_LAT range.
   localparam int DEPTH = (RD_LAT < 1) ? 1 : ((RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT);

   logic [DEPTH-1:0]            r_vld_pipe;
   logic [DEPTH-1:0][IDX_W-1:0] r_idx_pipe;

   // Shift valid/index tags one stage per cycle; reset drops in-flight tags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_pipe <= '0;
         r_idx_pipe <= '0;
      end else begin
         r_vld_pipe[0] <= i_issue;
         r_idx_pipe[0] <= i_index;
         for (int k = 1; k < DEPTH; k++) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            r_idx_pipe[k] <= r_idx_pipe[k-1];
         end
      end
   end

   assign o_cap_valid = r_vld_pipe[DEPTH-1];
   assign o_cap_index = r_idx_pipe[DEPTH-1];
endmodule

// File: rtl/ntt_bram_ctrl.sv
// ntt_bram_ctrl: loads N coefficients from BRAM into the x buffer, runs the
// external NTT core, then stores its y vector back to BRAM and pulses done.
// Optional macro NTT_BRAM_BITREV_EN: load into x[bitrev(index)] for DIT cores.
module ntt_bram_ctrl
   import ntt_pkg::*;
#(
   parameter int N        = 64,
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 12,
   parameter int IN_BASE  = 0,
   parameter int OUT_BASE = 64,
   parameter int ADDR_LSB = 2,
   parameter int RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   ntt_bram_ctrl_if.master   io_bus
);
   localparam int IDX_W = $clog2(N);
   localparam int CNT_W = IDX_W + 1;

   typedef logic [DATA_W-1:0] word_t;

   // Byte address of a word: 32-bit sum, shifted, then wrapped to ADDR_W.
   function automatic logic [ADDR_W-1:0] word_addr(input int unsigned base,
                                                   input logic [CNT_W-1:0] idx);
      logic [31:0] w;
      w = (32'(base) + 32'(idx)) << ADDR_LSB;
      return w[ADDR_W-1:0];
   endfunction

   state_e                     r_state, w_state_nxt;
   logic [CNT_W-1:0]           r_rd_i, w_rd_nxt;     // addresses issued so far
   logic [CNT_W-1:0]           r_wr_i, w_wr_nxt;     // writes presented so far
   logic [ADDR_W-1:0]          r_addr, w_addr_nxt;
   word_t                      r_din, w_din_nxt;
   logic                       r_iss_vld, w_iss_vld_nxt;
   logic [IDX_W-1:0]           r_iss_idx, w_iss_idx_nxt;
   logic [N-1:0][DATA_W-1:0]   r_x;
   logic [N-1:0][DATA_W-1:0]   r_y;
   logic                       w_cap_vld;
   logic [IDX_W-1:0]           w_cap_idx;
   logic [IDX_W-1:0]           w_x_idx;
   logic                       w_load_last;

   // The tag rides alongside the address currently on the bus.
   bram_rd_tracker #(.RD_LAT(RD_LAT), .IDX_W(IDX_W)) u_rd_tracker (
      .clk         (clk),
      .rst         (rst),
      .i_issue     (r_iss_vld),
      .i_index     (r_iss_idx),
      .o_cap_valid (w_cap_vld),
      .o_cap_index (w_cap_idx)
   );

`ifdef NTT_BRAM_BITREV_EN
   assign w_x_idx = IDX_W'(bitrev(32'(w_cap_idx), IDX_W));
`else
   assign w_x_idx = w_cap_idx;
`endif

   // Last tag emerging means every read has landed; LOAD ends this cycle.
   assign w_load_last = w_cap_vld && (w_cap_idx == IDX_W'(N-1));

   // Next-state and next registered bus values.
   always_comb begin
      w_state_nxt   = r_state;
      w_rd_nxt      = r_rd_i;
      w_wr_nxt      = r_wr_i;
      w_addr_nxt    = '0;
      w_din_nxt     = '0;
      w_iss_vld_nxt = 1'b0;
      w_iss_idx_nxt = '0;
      unique case (r_state)
         IDLE: begin
            if (io_bus.start) begin
               w_state_nxt   = LOAD;
               w_addr_nxt    = word_addr(IN_BASE, '0);
               w_iss_vld_nxt = 1'b1;
               w_rd_nxt      = CNT_W'(1);
            end
         end
         LOAD: begin
            if (r_rd_i < CNT_W'(N)) begin
               w_addr_nxt    = word_addr(IN_BASE, r_rd_i);
               w_iss_vld_nxt = 1'b1;
               w_iss_idx_nxt = r_rd_i[IDX_W-1:0];
               w_rd_nxt      = r_rd_i + CNT_W'(1);
            end else begin
               w_addr_nxt    = r_addr;   // drain: hold the last address
            end
            if (w_load_last) begin
               w_state_nxt = RUN;
               w_addr_nxt  = '0;
               w_rd_nxt    = '0;
            end
         end
         RUN: begin
            if (io_bus.core_done) begin
               w_state_nxt = STORE;
               w_addr_nxt  = word_addr(OUT_BASE, '0);
               w_din_nxt   = io_bus.core_y[DATA_W-1:0];
               w_wr_nxt    = CNT_W'(1);
            end
         end
         STORE: begin
            if (r_wr_i == CNT_W'(N)) begin
               w_state_nxt = FIN;
               w_wr_nxt    = '0;
            end else begin
               w_addr_nxt = word_addr(OUT_BASE, r_wr_i);
               w_din_nxt  = r_y[r_wr_i[IDX_W-1:0]];
               w_wr_nxt   = r_wr_i + CNT_W'(1);
            end
         end
         FIN:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, counters and registered BRAM address/data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rd_i    <= '0;
         r_wr_i    <= '0;
         r_addr    <= '0;
         r_din     <= '0;
         r_iss_vld <= 1'b0;
         r_iss_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_i    <= w_rd_nxt;
         r_wr_i    <= w_wr_nxt;
         r_addr    <= w_addr_nxt;
         r_din     <= w_din_nxt;
         r_iss_vld <= w_iss_vld_nxt;
         r_iss_idx <= w_iss_idx_nxt;
      end
   end

   // x captures read data as tags emerge; y snapshots the core on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x <= '0;
         r_y <= '0;
      end else begin
         if ((r_state == LOAD) && w_cap_vld) r_x[w_x_idx] <= io_bus.BRAM_dout;
         if ((r_state == RUN) && io_bus.core_done) r_y <= io_bus.core_y;
      end
   end

   assign io_bus.busy      = (r_state != IDLE);
   assign io_bus.done      = (r_state == FIN);
   assign io_bus.BRAM_en   = (r_state == LOAD) || (r_state == STORE);
   assign io_bus.BRAM_we   = (r_state == STORE);
   assign io_bus.BRAM_addr = r_addr;
   assign io_bus.BRAM_din  = r_din;
   assign io_bus.BRAM_clk  = clk;
   assign io_bus.BRAM_rst  = rst;
   assign io_bus.core_rst  = (r_state != RUN);
   assign io_bus.core_x    = r_x;
endmodule

// File: tb/tb_ntt_bram_ctrl.sv
// Bench for ntt_bram_ctrl: two instances (N=64/RD_LAT=1 and N=8/RD_LAT=3,
// IN_BASE=16) with behavioural BRAM and NTT-core models. Expected memory and
// x contents come from the bench's own copy of what it wrote into BRAM.
module tb_ntt_bram_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   ntt_bram_ctrl_if #(.N(64), .DATA_W(64), .ADDR_W(12)) ia();
   ntt_bram_ctrl_if #(.N(8),  .DATA_W(64), .ADDR_W(12)) ib();

   ntt_bram_ctrl #(.N(64), .DATA_W(64), .ADDR_W(12), .IN_BASE(0), .OUT_BASE(64),
                   .ADDR_LSB(2), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst_a), .io_bus(ia.master));
   ntt_bram_ctrl #(.N(8), .DATA_W(64), .ADDR_W(12), .IN_BASE(16), .OUT_BASE(32),
                   .ADDR_LSB(2), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst_b), .io_bus(ib.master));

   // BRAM models (word-addressed by BRAM_addr>>2) with a bench write port.
   logic [63:0] mem_a [1024];
   logic [63:0] mem_b [1024];
   logic [63:0] ref_a [1024];
   logic [63:0] ref_b [1024];
   logic [63:0] dout_a;
   logic [63:0] pb0, pb1, pb2;
   logic        tbw_en, tbw_b;
   logic [9:0]  tbw_idx;
   logic [63:0] tbw_dat;

   always @(posedge clk) begin
      if (tbw_en && !tbw_b) mem_a[tbw_idx] <= tbw_dat;
      else if (ia.BRAM_en && ia.BRAM_we) mem_a[ia.BRAM_addr[11:2]] <= ia.BRAM_din;
      dout_a <= mem_a[ia.BRAM_addr[11:2]];
   end
   assign ia.BRAM_dout = dout_a;

   always @(posedge clk) begin
      if (tbw_en && tbw_b) mem_b[tbw_idx] <= tbw_dat;
      else if (ib.BRAM_en && ib.BRAM_we) mem_b[ib.BRAM_addr[11:2]] <= ib.BRAM_din;
      pb0 <= mem_b[ib.BRAM_addr[11:2]];
      pb1 <= pb0;
      pb2 <= pb1;
   end
   assign ib.BRAM_dout = pb2;

   // Core models: y = x + 1, core_done 10 cycles after core_rst falls.
   int ccnt_a, ccnt_b;
   always @(posedge clk) begin
      if (ia.core_rst) ccnt_a <= 0; else if (ccnt_a < 10) ccnt_a <= ccnt_a + 1;
      if (ib.core_rst) ccnt_b <= 0; else if (ccnt_b < 10) ccnt_b <= ccnt_b + 1;
   end
   assign ia.core_done = !ia.core_rst && (ccnt_a >= 10);
   assign ib.core_done = !ib.core_rst && (ccnt_b >= 10);
   always_comb begin
      ia.core_y = '0;
      for (int i = 0; i < 64; i++) ia.core_y[i*64 +: 64] = ia.core_x[i*64 +: 64] + 64'd1;
   end
   always_comb begin
      ib.core_y = '0;
      for (int i = 0; i < 8; i++) ib.core_y[i*64 +: 64] = ib.core_x[i*64 +: 64] + 64'd1;
   end

   // Bus monitor.
   logic mon_clr;
   int rd_a, wr_a, done_a, frd_a, fwr_a, rd_b, wr_b, done_b, frd_b, fwr_b;
   always @(negedge clk) begin
      if (mon_clr) begin
         rd_a <= 0; wr_a <= 0; done_a <= 0; frd_a <= -1; fwr_a <= -1;
         rd_b <= 0; wr_b <= 0; done_b <= 0; frd_b <= -1; fwr_b <= -1;
      end else begin
         if (ia.BRAM_en && !ia.BRAM_we) begin
            rd_a <= rd_a + 1; if (frd_a < 0) frd_a <= int'(ia.BRAM_addr);
         end
         if (ia.BRAM_en && ia.BRAM_we) begin
            wr_a <= wr_a + 1; if (fwr_a < 0) fwr_a <= int'(ia.BRAM_addr);
         end
         if (ia.done) done_a <= done_a + 1;
         if (ib.BRAM_en && !ib.BRAM_we) begin
            rd_b <= rd_b + 1; if (frd_b < 0) frd_b <= int'(ib.BRAM_addr);
         end
         if (ib.BRAM_en && ib.BRAM_we) begin
            wr_b <= wr_b + 1; if (fwr_b < 0) fwr_b <= int'(ib.BRAM_addr);
         end
         if (ib.done) done_b <= done_b + 1;
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Where coefficient j of x comes from, relative to the input base.
   function automatic int perm(input int i, input int bits);
      int r;
      r = i;
`ifdef NTT_BRAM_BITREV_EN
      r = 0;
      for (int k = 0; k < bits; k++) if (((i >> k) & 1) == 1) r += (1 << (bits - 1 - k));
`endif
      return (bits > 0) ? r : i;
   endfunction

   task automatic mem_wr(input bit b, input int idx, input logic [63:0] d);
      tbw_en = 1'b1; tbw_b = b; tbw_idx = 10'(idx); tbw_dat = d;
      @(negedge clk);
      tbw_en = 1'b0;
      if (b) ref_b[idx] = d; else ref_a[idx] = d;
   endtask

   task automatic clear_mon();
      @(posedge clk); mon_clr = 1'b1;
      @(posedge clk); mon_clr = 1'b0;
      @(negedge clk);
   endtask

   // Start one transfer; cyc counts cycles from the start cycle to done inclusive.
   task automatic run(input bit b, input bit poke, output int cyc);
      bit st;
      clear_mon();
      if (b) ib.start = 1'b1; else ia.start = 1'b1;
      cyc = 1;
      while (!(b ? ib.done : ia.done) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         st = poke && (cyc == 10 || cyc == 70 || cyc == 100);
         if (b) ib.start = 1'b0; else ia.start = st;
      end
      chk(b ? "b_done_seen" : "a_done_seen", 64'(b ? ib.done : ia.done), 64'd1);
      if (poke) ia.start = 1'b1;   // start coinciding with done
      @(negedge clk);
      ia.start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic verify_a(input string tag, input int nwr);
      logic [63:0] e;
      for (int i = 0; i < 64; i++) begin
         e = (i < nwr) ? ref_a[perm(i, 6)] + 64'd1 : ref_a[64+i];
         chk($sformatf("%s_out[%0d]", tag, i), mem_a[64+i], e);
         ref_a[64+i] = e;
      end
   endtask

   task automatic verify_b(input string tag);
      logic [63:0] e;
      for (int j = 0; j < 8; j++)
         chk($sformatf("%s_x[%0d]", tag, j), ib.core_x[j*64 +: 64], ref_b[16 + perm(j, 3)]);
      for (int i = 0; i < 8; i++) begin
         e = ref_b[16 + perm(i, 3)] + 64'd1;
         chk($sformatf("%s_out[%0d]", tag, i), mem_b[32+i], e);
         ref_b[32+i] = e;
      end
   endtask

   initial begin
      int cyc, nst, guard;
      int exp_tab[8];
`ifdef NTT_BRAM_BITREV_EN
      exp_tab = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
      exp_tab = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
      ia.start = 1'b0; ib.start = 1'b0;
      tbw_en = 1'b0; tbw_b = 1'b0; tbw_idx = '0; tbw_dat = '0;
      mon_clr = 1'b1;
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (3) @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; mon_clr = 1'b0;
      @(negedge clk);

      chk("rst_busy",     64'(ia.busy),      64'd0);
      chk("rst_done",     64'(ia.done),      64'd0);
      chk("rst_en",       64'(ia.BRAM_en),   64'd0);
      chk("rst_we",       64'(ia.BRAM_we),   64'd0);
      chk("rst_core_rst", 64'(ia.core_rst),  64'd1);
      chk("rst_addr",     64'(ia.BRAM_addr), 64'd0);
      chk("rst_b_x0",     ib.core_x[63:0],   64'd0);

      // Pass A1: word i = 0x1000+i, plain run.
      for (int i = 0; i < 64; i++) mem_wr(1'b0, i, 64'h1000 + 64'(i));
      for (int i = 0; i < 64; i++) mem_wr(1'b0, 64 + i, 64'hDEAD_0000 + 64'(i));
      run(1'b0, 1'b0, cyc);
      chk("a_start_to_done", 64'(cyc), 64'd142);
      chk("a_first_rd",      64'(frd_a), 64'h000);
      chk("a_first_wr",      64'(fwr_a), 64'h100);
      chk("a_reads",         64'(rd_a),  64'd65);
      chk("a_writes",        64'(wr_a),  64'd64);
      chk("a_done_pulses",   64'(done_a), 64'd1);
      verify_a("a1", 64);

      // Pass B1: N=8, RD_LAT=3, IN_BASE=16, word 16+i = i.
      for (int i = 0; i < 8; i++) mem_wr(1'b1, 16 + i, 64'(i));
      run(1'b1, 1'b0, cyc);
      chk("b_start_to_done", 64'(cyc),   64'd32);
      chk("b_load_cycles",   64'(rd_b),  64'd11);
      chk("b_first_rd",      64'(frd_b), 64'h040);
      chk("b_first_wr",      64'(fwr_b), 64'h080);
      chk("b_writes",        64'(wr_b),  64'd8);
      for (int j = 0; j < 8; j++)
         chk($sformatf("b_order[%0d]", j), ib.core_x[j*64 +: 64], 64'(exp_tab[j]));
      verify_b("b1");

      // Pass B2: random coefficients.
      for (int i = 0; i < 8; i++) mem_wr(1'b1, 16 + i, {$urandom, $urandom});
      run(1'b1, 1'b0, cyc);
      chk("b2_done_pulses", 64'(done_b), 64'd1);
      verify_b("b2");

      // Pass A2: random data, start poked in LOAD, RUN, STORE and FIN.
      for (int i = 0; i < 64; i++) mem_wr(1'b0, i, {$urandom, $urandom});
      run(1'b0, 1'b1, cyc);
      chk("a2_start_to_done", 64'(cyc),    64'd142);
      chk("a2_reads",         64'(rd_a),   64'd65);
      chk("a2_writes",        64'(wr_a),   64'd64);
      chk("a2_done_pulses",   64'(done_a), 64'd1);
      chk("a2_idle_after",    64'(ia.busy), 64'd0);
      verify_a("a2", 64);

      // Pass A3: reset during the 4th STORE write cycle.
      for (int i = 0; i < 64; i++) mem_wr(1'b0, i, {$urandom, $urandom});
      for (int i = 0; i < 64; i++) mem_wr(1'b0, 64 + i, 64'hBAD0_0000 + 64'(i));
      ia.start = 1'b1;
      nst = 0; guard = 0;
      while (nst < 4 && guard < 3000) begin
         @(negedge clk);
         ia.start = 1'b0;
         guard++;
         if (ia.BRAM_we) nst++;
      end
      chk("a3_store_reached", 64'(nst), 64'd4);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      chk("a3_busy",     64'(ia.busy),      64'd0);
      chk("a3_we",       64'(ia.BRAM_we),   64'd0);
      chk("a3_en",       64'(ia.BRAM_en),   64'd0);
      chk("a3_core_rst", 64'(ia.core_rst),  64'd1);
      chk("a3_addr",     64'(ia.BRAM_addr), 64'd0);
      repeat (3) @(negedge clk);
      verify_a("a3", 4);

      // Pass A4: clean run after the aborted one.
      run(1'b0, 1'b0, cyc);
      chk("a4_start_to_done", 64'(cyc),    64'd142);
      chk("a4_done_pulses",   64'(done_a), 64'd1);
      verify_a("a4", 64);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
